// File: rtl/bus_slave_mux_ng.sv
// Registered slave-response multiplexer: lowest-index chip select wins.
// A missing slave or a hung slave gets a decode/timeout error response instead of stalling the master.
module bus_slave_mux_ng #(
  parameter  int            NSLV     = 8,
  parameter  int            DW       = 32,
  parameter  int            TIMEOUT  = 255,
  parameter  logic [DW-1:0] ERR_DATA = '0,
  localparam int            IW       = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 m_req,
  input  logic [NSLV-1:0]      s_cs,
  input  logic [NSLV-1:0]      s_rdy,
  input  logic [NSLV*DW-1:0]   s_data_i,
  input  logic                 clr_err,
  output logic                 s_ready,
  output logic [DW-1:0]        s_data_o,
  output logic                 s_err,
  output logic [IW-1:0]        sel_idx,
  output logic                 timeout_o,
  output logic                 conflict_o
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic                      r_ready, r_err, r_to, r_conf;
  logic [DW-1:0]             r_data;
  logic [IW-1:0]             r_sel;

  logic [NSLV-1:0][DW-1:0]   w_slv;
  logic                      w_hit, w_rdy, w_multi, w_tmo;
  logic [IW-1:0]             w_idx;
  logic [DW-1:0]             w_data;

  assign w_slv = s_data_i;

  // Scanning downward leaves the lowest asserted index as the winner.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (s_cs[k]) begin
        w_hit = 1'b1;
        w_idx = IW'(k);
      end
    end
  end

  assign w_data  = w_slv[w_idx];
  assign w_rdy   = s_rdy[w_idx];
  assign w_multi = |(s_cs & (s_cs - NSLV'(1)));
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_to    <= 1'b0;
      r_conf  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      // Sticky flags: a set event in the same cycle overrides clr_err.
      r_conf  <= (m_req & w_multi) | (r_conf & ~clr_err);
      r_to    <= r_to & ~clr_err;
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (!m_req) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (!w_hit) begin
            r_state <= S_ERR;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_data  <= ERR_DATA;
          end else if (w_rdy) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_data  <= w_data;
            r_sel   <= w_idx;
          end else if (w_tmo) begin
            r_state <= S_ERR;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_data  <= ERR_DATA;
            r_to    <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP, S_ERR: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign s_ready    = r_ready;
  assign s_err      = r_err;
  assign s_data_o   = r_data;
  assign sel_idx    = r_sel;
  assign timeout_o  = r_to;
  assign conflict_o = r_conf;

endmodule

// File: tb/tb_bus_slave_mux_ng.sv
// Directed + randomized bench for bus_slave_mux_ng; expectations come from a
// transaction-level model (response edge, winner, data, sticky flags).
module tb_bus_slave_mux_ng;
  localparam int            NSLV     = 8;
  localparam int            DW       = 32;
  localparam int            TIMEOUT  = 4;
  localparam logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    m_req, clr_err;
  logic [NSLV-1:0]         s_cs, s_rdy;
  logic [NSLV-1:0][DW-1:0] sd;
  logic                    s_ready, s_err, timeout_o, conflict_o;
  logic [DW-1:0]           s_data_o;
  logic [2:0]              sel_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_data;
  logic [2:0]    exp_sel;
  logic          exp_to, exp_conf;

  bus_slave_mux_ng #(.NSLV(NSLV), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .s_cs(s_cs), .s_rdy(s_rdy),
    .s_data_i(sd), .clr_err(clr_err), .s_ready(s_ready), .s_data_o(s_data_o),
    .s_err(s_err), .sel_idx(sel_idx), .timeout_o(timeout_o), .conflict_o(conflict_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic err);
    check({tag, ".ready"},    64'(s_ready),    64'(rdy));
    check({tag, ".err"},      64'(s_err),      64'(err));
    check({tag, ".data"},     64'(s_data_o),   64'(exp_data));
    check({tag, ".sel"},      64'(sel_idx),    64'(exp_sel));
    check({tag, ".timeout"},  64'(timeout_o),  64'(exp_to));
    check({tag, ".conflict"}, 64'(conflict_o), 64'(exp_conf));
  endtask

  // One master access. The selected slave stays not-ready for d sampling edges.
  task automatic run_txn(input string tag, input logic [NSLV-1:0] cs, input int d, input bit clr);
    bit  hit = 0;
    int  sel = 0;
    int  e;
    bit  tmo;
    for (int i = NSLV - 1; i >= 0; i--) if (cs[i]) begin hit = 1; sel = i; end
    if (hit) s_rdy[sel] = (d == 0);
    e   = !hit ? 1 : ((d < TIMEOUT) ? d + 1 : TIMEOUT);
    tmo = hit && (d >= TIMEOUT);
    if (clr) begin exp_to = 1'b0; exp_conf = 1'b0; end
    if ($countones(cs) > 1) exp_conf = 1'b1;
    if (tmo) exp_to = 1'b1;
    if (hit && !tmo) begin exp_data = sd[sel]; exp_sel = 3'(sel); end
    else exp_data = ERR_DATA;
    m_req = 1'b1; s_cs = cs; clr_err = clr;
    for (int k = 1; k <= e; k++) begin
      tick();
      clr_err = 1'b0;
      if (k < e) check({tag, ".early"}, 64'(s_ready), 64'd0);
      if (hit && k == d) s_rdy[sel] = 1'b1;
    end
    check_all(tag, 1'b1, !(hit && !tmo));
    tick();
    check({tag, ".pulse"}, 64'(s_ready), 64'd0);
    check({tag, ".hold"},  64'(s_data_o), 64'(exp_data));
    m_req = 1'b0; s_cs = '0;
    tick();
    check({tag, ".idle"}, 64'(s_ready), 64'd0);
  endtask

  task automatic clr_idle(input string tag);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_to = 1'b0; exp_conf = 1'b0;
    check({tag, ".timeout"},  64'(timeout_o),  64'd0);
    check({tag, ".conflict"}, 64'(conflict_o), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; m_req = 1'b0; clr_err = 1'b0; s_cs = '0; s_rdy = '0; sd = '0;
    exp_data = '0; exp_sel = '0; exp_to = 1'b0; exp_conf = 1'b0;
    tick(); tick();
    check_all("reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    check_all("post_reset", 1'b0, 1'b0);

    sd[3] = 32'h1234_5678;
    run_txn("basic", 8'b0000_1000, 0, 0);

    sd[0] = 32'hA5A5_A5A5;
    run_txn("wait3", 8'b0000_0001, 3, 0);

    run_txn("decode", 8'b0000_0000, 0, 0);

    run_txn("timeout", 8'b0000_0100, 99, 0);
    clr_idle("clr_after_tmo");

    sd[1] = 32'h11; sd[2] = 32'h22; s_rdy = 8'b0000_0100;
    run_txn("prio", 8'b0000_0110, 0, 1);
    check("conf_sticky", 64'(conflict_o), 64'd1);
    clr_idle("clr_after_conf");

    // Abort in WAIT: no response, and the next access gets the full wait budget.
    s_rdy = '0; s_cs = 8'b0000_0100; m_req = 1'b1;
    for (int k = 0; k < 2; k++) begin tick(); check("abort.wait", 64'(s_ready), 64'd0); end
    m_req = 1'b0; s_cs = '0;
    for (int k = 0; k < 3; k++) begin tick(); check("abort.none", 64'(s_ready), 64'd0); end
    run_txn("after_abort", 8'b0000_0100, 99, 0);

    for (int t = 0; t < 40; t++) begin
      int r;
      logic [NSLV-1:0] cs;
      for (int i = 0; i < NSLV; i++) sd[i] = $urandom;
      s_rdy = NSLV'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0)     cs = '0;
      else if (r < 5) cs = NSLV'(1) << $urandom_range(0, NSLV - 1);
      else            cs = NSLV'($urandom);
      run_txn("rand", cs, $urandom_range(0, 6), $urandom_range(0, 5) == 0);
    end

    // Reset while waiting on a slave: outputs drop immediately, nothing pending afterwards.
    s_rdy = '0; s_cs = 8'b0001_0000; m_req = 1'b1;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    exp_data = '0; exp_sel = '0; exp_to = 1'b0; exp_conf = 1'b0;
    check_all("async_reset", 1'b0, 1'b0);
    m_req = 1'b0; s_cs = '0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("post_mid_reset", 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
